// File: rtl/spm_pkg.sv
// Shared definitions for the SPM sequencer and its serial multiplier core.
package spm_pkg;

    localparam int SPM_WIDTH   = 8;
    localparam int SPM_PWIDTH  = 2 * SPM_WIDTH;
    localparam int SPM_LATENCY = SPM_PWIDTH + 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } spm_state_e;

endpackage

// File: rtl/SPM.sv
// Bit-serial signed multiplier core: parallel multiplicand, LSB-first
// multiplier stream, registered LSB-first product stream.
module SPM #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic             x_bit_i,
    output logic             p_bit_o
);

    localparam int AW = 2 * WIDTH;

    // acc holds the running partial product already shifted right by the
    // number of bits emitted; its magnitude never exceeds the multiplicand.
    logic [AW-1:0] acc_q;
    logic [AW-1:0] acc_d;
    logic          p_q;
    logic          p_d;
    logic [AW:0]   addend;
    logic [AW:0]   sum;

    always_comb begin
        addend = '0;
        if (x_bit_i) begin
            addend = {{(AW + 1 - WIDTH){mcand_i[WIDTH-1]}}, mcand_i};
        end
        sum   = {acc_q[AW-1], acc_q} + addend;
        p_d   = sum[0];
        acc_d = sum[AW:1];
        if (clr_i) begin
            p_d   = 1'b0;
            acc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            p_q   <= 1'b0;
        end else begin
            acc_q <= acc_d;
            p_q   <= p_d;
        end
    end

    assign p_bit_o = p_q;

endmodule

// File: rtl/spm_serial_capture.sv
// Shift-right collector: serial product bits enter at the MSB, so after
// PW shifts the LSB-first stream sits in natural bit order.
module spm_serial_capture #(
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          sync_clr_i,
    input  logic          shift_en_i,
    input  logic          bit_i,
    output logic [PW-1:0] q_o
);

    logic [PW-1:0] q_q;
    logic [PW-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (sync_clr_i) begin
            q_d = '0;
        end else if (shift_en_i) begin
            q_d = {bit_i, q_q[PW-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q_o = q_q;

endmodule

// File: rtl/spm_sequencer.sv
// Sequencer around the SPM core: latches operands, streams the sign-extended
// multiplier, collects the serial product and presents it with a done pulse.
module spm_sequencer
    import spm_pkg::*;
#(
    parameter int WIDTH = SPM_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               core_clr,
    output logic [WIDTH-1:0]   core_mcand,
    output logic               core_x_bit,
    input  logic               core_p_bit
);

    localparam int PW = 2 * WIDTH;
    localparam int KW = $clog2(PW);
    localparam int IW = $clog2(WIDTH);
    localparam logic [KW-1:0] K_LAST = KW'(PW - 1);

    spm_state_e     state_q, state_d;
    logic [KW-1:0]  k_q, k_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mult_q, mult_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           clr_q, clr_d;
    logic           x_q, x_d;
    logic [PW-1:0]  product_q, product_d;
    logic           accept;
    logic           cap_shift;
    logic [PW-1:0]  cap_q;
    logic           cap_lsb_unused;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        accept    = 1'b0;
        cap_shift = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = SHIFT;
                k_d     = '0;
            end
            SHIFT: begin
                // Product bit k-1 arrives while bit k is driven; bit 0 has no predecessor.
                cap_shift = (k_q != '0);
                if (k_q == K_LAST) begin
                    state_d = DRAIN;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DRAIN: begin
                cap_shift = 1'b1;
                state_d   = DONE;
            end
            DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = CLEAR;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
            end
        endcase

        mcand_d = accept ? multiplicand : mcand_q;
        mult_d  = accept ? multiplier   : mult_q;

        busy_d = (state_d == CLEAR) || (state_d == SHIFT) || (state_d == DRAIN);
        done_d = (state_d == DONE);
        clr_d  = (state_d == CLEAR);

        x_d = 1'b0;
        if (state_d == SHIFT) begin
            if (k_d >= KW'(WIDTH)) begin
                x_d = mult_q[WIDTH-1];
            end else begin
                x_d = mult_q[k_d[IW-1:0]];
            end
        end

        // The last bit is shifted in on the same edge that publishes the product.
        product_d = product_q;
        if (state_q == DRAIN) begin
            product_d = {core_p_bit, cap_q[PW-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            mcand_q   <= '0;
            mult_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            clr_q     <= 1'b0;
            x_q       <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            mcand_q   <= mcand_d;
            mult_q    <= mult_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            clr_q     <= clr_d;
            x_q       <= x_d;
            product_q <= product_d;
        end
    end

    spm_serial_capture #(
        .PW (PW)
    ) u_capture (
        .clk        (clk),
        .sync_clr_i (rst),
        .shift_en_i (cap_shift),
        .bit_i      (core_p_bit),
        .q_o        (cap_q)
    );

    assign cap_lsb_unused = cap_q[0];

    assign busy       = busy_q;
    assign done       = done_q;
    assign product    = product_q;
    assign core_clr   = clr_q;
    assign core_mcand = mcand_q;
    assign core_x_bit = x_q;

endmodule

// File: tb/tb_spm_sequencer.sv
// Directed bench for spm_sequencer driving the real SPM core.
module tb_spm_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        core_clr;
    logic [7:0]  core_mcand;
    logic        core_x_bit;
    logic        core_p_bit;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0]  mc;
        logic [7:0]  mp;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[8];

    spm_sequencer #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .core_clr     (core_clr),
        .core_mcand   (core_mcand),
        .core_x_bit   (core_x_bit),
        .core_p_bit   (core_p_bit)
    );

    SPM #(.WIDTH(8)) u_core (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (core_clr),
        .mcand_i (core_mcand),
        .x_bit_i (core_x_bit),
        .p_bit_o (core_p_bit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [7:0] mc, input logic [7:0] mp);
        multiplicand = mc;
        multiplier   = mp;
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int got;
        int idx;
        logic [7:0] m;
        m = v.mp;
        start_op(v.mc, v.mp);
        check("clear_cycle_clr", core_clr, 1);
        check("clear_cycle_busy", busy, 1);
        check("latched_mcand", core_mcand, v.mc);
        got = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n <= 16) begin
                idx = (n - 1 > 7) ? 7 : n - 1;
                check($sformatf("x_bit_k%0d", n - 1), core_x_bit, m[idx]);
            end
            if (n < 18) check($sformatf("busy_e%0d", n), busy, 1);
            if (done === 1'b1) begin
                got = n;
                break;
            end
        end
        check("latency", got, 18);
        check("done_busy_low", busy, 0);
        check($sformatf("product_%0h_x_%0h", v.mc, v.mp), product, v.exp);
        tick();
        check("done_one_cycle", done, 0);
        check("product_held", product, v.exp);
    endtask

    initial begin
        int  n;
        logic saw_done;

        rst          = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;

        vecs[0] = '{mc: 8'h03, mp: 8'h05, exp: 16'h000F};
        vecs[1] = '{mc: 8'hFD, mp: 8'h05, exp: 16'hFFF1};
        vecs[2] = '{mc: 8'h80, mp: 8'h80, exp: 16'h4000};
        vecs[3] = '{mc: 8'h7F, mp: 8'h80, exp: 16'hC080};
        vecs[4] = '{mc: 8'h00, mp: 8'hFF, exp: 16'h0000};
        vecs[5] = '{mc: 8'h7F, mp: 8'h7F, exp: 16'h3F01};
        vecs[6] = '{mc: 8'h81, mp: 8'h7F, exp: 16'hC0FF};
        vecs[7] = '{mc: 8'hFF, mp: 8'hFF, exp: 16'h0001};

        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_product", product, 0);
        check("rst_core_clr", core_clr, 0);
        check("rst_core_mcand", core_mcand, 0);
        check("rst_core_x_bit", core_x_bit, 0);
        rst = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // start pulsed mid-operation must be ignored
        start_op(8'h03, 8'h05);
        repeat (4) tick();
        multiplicand = 8'h09;
        multiplier   = 8'h09;
        start        = 1'b1;
        tick();
        start        = 1'b0;
        check("ignore_mcand_kept", core_mcand, 8'h03);
        check("ignore_busy", busy, 1);
        wait_done(n);
        check("ignore_latency", n, 13);
        check("ignore_product", product, 16'h000F);
        tick();

        // start held high: re-acceptance on the done cycle
        multiplicand = 8'h06;
        multiplier   = 8'h07;
        start        = 1'b1;
        tick();
        multiplicand = 8'hFF;
        multiplier   = 8'hFF;
        wait_done(n);
        check("b2b_first_latency", n, 18);
        check("b2b_first_product", product, 16'h002A);
        tick();
        start = 1'b0;
        check("b2b_restart_done_low", done, 0);
        check("b2b_restart_busy", busy, 1);
        check("b2b_restart_mcand", core_mcand, 8'hFF);
        wait_done(n);
        check("b2b_second_spacing", n + 1, 19);
        check("b2b_second_product", product, 16'h0001);
        tick();

        // reset in the middle of a run
        start_op(8'h07, 8'h07);
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_product", product, 0);
        check("midrst_core_clr", core_clr, 0);
        check("midrst_core_mcand", core_mcand, 0);
        check("midrst_core_x_bit", core_x_bit, 0);
        saw_done = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        check("midrst_no_done", saw_done, 0);
        run_vec('{mc: 8'h02, mp: 8'hFE, exp: 16'hFFFC});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
